// File: rtl/service_window_client_if.sv
// Service-window client bus: host write port, window request/status, served-word output
// and status pulses. Clock and reset stay outside the interface.
//   slave  : view used by service_window_client (receives wdata/wvalid/start/swstat).
//   master : view used by the host / environment driving the client.
interface service_window_client_if;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;
  logic       start;
  logic       init;
  logic [7:0] swlen;
  logic       swstat;
  logic [7:0] txdata;
  logic       txvalid;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic       short_err;

  modport slave (
    input  wdata, wvalid, start, swstat,
    output wready, init, swlen, txdata, txvalid, busy, done, timeout_err, short_err
  );

  modport master (
    output wdata, wvalid, start, swstat,
    input  wready, init, swlen, txdata, txvalid, busy, done, timeout_err, short_err
  );
endinterface

// File: rtl/service_window_client.sv
// Initiator-side service-window controller.
// Queues 8-bit words in a FIFO; on start requests a window with a one-cycle active-low
// init and swlen = queued count, then drains that many words one per cycle while swstat
// is high. Reports done, timeout_err (window never opened) and short_err (window closed
// early; unsent words stay queued in order).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : service_window_client_if.slave (wdata/wvalid/wready host port, start, init,
//          swlen, swstat, txdata/txvalid, busy, done, timeout_err, short_err)
// All bus outputs are registered except wready, which decodes the FIFO count directly.
module service_window_client #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    rst,
  service_window_client_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StArm, StWaitOpen, StServe, StClose} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  // FSM state and registered outputs
  state_e        state_q, state_d;
  logic [7:0]    swlen_q, swlen_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          init_q, init_d;
  logic [7:0]    txdata_q, txdata_d;
  logic          txvalid_q, txvalid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tout_q, tout_d;
  logic          short_q, short_d;

  assign bus.wready = (count_q < CW'(DEPTH));
  assign push       = bus.wvalid && bus.wready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    swlen_d   = swlen_q;
    rem_d     = rem_q;
    timer_d   = timer_q;
    init_d    = 1'b1;
    txdata_d  = txdata_q;
    txvalid_d = 1'b0;
    done_d    = 1'b0;
    tout_d    = 1'b0;
    short_d   = 1'b0;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        // Only words already queued at start belong to this window.
        if (bus.start && (count_q != '0)) begin
          state_d = StArm;
          swlen_d = 8'(count_q);
          rem_d   = count_q;
          init_d  = 1'b0;
        end
      end
      StArm: begin
        state_d = StWaitOpen;
        timer_d = '0;
      end
      StWaitOpen: begin
        if (bus.swstat) begin
          pop       = 1'b1;
          txdata_d  = mem[rptr_q];
          txvalid_d = 1'b1;
          rem_d     = rem_q - CW'(1);
          state_d   = StServe;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StServe: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = StClose;
        end else if (bus.swstat) begin
          pop       = 1'b1;
          txdata_d  = mem[rptr_q];
          txvalid_d = 1'b1;
          rem_d     = rem_q - CW'(1);
        end else begin
          short_d = 1'b1;
          state_d = StIdle;
        end
      end
      StClose: begin
        if (!bus.swstat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      swlen_q   <= '0;
      rem_q     <= '0;
      timer_q   <= '0;
      init_q    <= 1'b1;
      txdata_q  <= '0;
      txvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      swlen_q   <= swlen_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      init_q    <= init_d;
      txdata_q  <= txdata_d;
      txvalid_q <= txvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
      short_q   <= short_d;
    end
  end

  assign bus.init        = init_q;
  assign bus.swlen       = swlen_q;
  assign bus.txdata      = txdata_q;
  assign bus.txvalid     = txvalid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tout_q;
  assign bus.short_err   = short_q;

endmodule

// File: tb/tb_service_window_client.sv
module tb_service_window_client;
  logic clk = 1'b0;
  logic rst = 1'b1;

  service_window_client_if bus();

  service_window_client #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Negedge monitor: accumulates pulses and served words; tasks look at deltas.
  int         init_lows = 0;
  int         dones     = 0;
  int         shorts    = 0;
  int         touts     = 0;
  logic [7:0] tx_q [$];

  always @(negedge clk) begin
    if (bus.init === 1'b0)        init_lows++;
    if (bus.done === 1'b1)        dones++;
    if (bus.short_err === 1'b1)   shorts++;
    if (bus.timeout_err === 1'b1) touts++;
    if (bus.txvalid === 1'b1)     tx_q.push_back(bus.txdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    bus.wdata  = d;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Open the window one cycle after init, hold it for hi cycles, then let it close.
  task automatic serve_window(input int hi);
    tick();
    bus.swstat = 1'b1;
    repeat (hi) tick();
    bus.swstat = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (bus.init !== 1'b1) begin miscompares++;
      $display("FAIL reset_init: got %b expected 1", bus.init); end
    vectors++; if (bus.swlen !== 8'h00) begin miscompares++;
      $display("FAIL reset_swlen: got %h expected 00", bus.swlen); end
    vectors++; if (bus.txdata !== 8'h00) begin miscompares++;
      $display("FAIL reset_txdata: got %h expected 00", bus.txdata); end
    vectors++; if ({bus.txvalid, bus.busy, bus.done, bus.timeout_err, bus.short_err} !== 5'b0)
      begin miscompares++; $display("FAIL reset_flags: got %b expected 00000",
        {bus.txvalid, bus.busy, bus.done, bus.timeout_err, bus.short_err}); end
    vectors++; if (bus.wready !== 1'b1) begin miscompares++;
      $display("FAIL reset_wready: got %b expected 1", bus.wready); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp [$];
    logic [7:0] got;
    int snap_tx = tx_q.size();
    int snap_init = init_lows;
    int snap_done = dones;
    write_word(8'hA1); write_word(8'hA2); write_word(8'hA3);
    pulse_start();
    vectors++; if (bus.init !== 1'b0) begin miscompares++;
      $display("FAIL basic_init_low: got %b expected 0", bus.init); end
    vectors++; if (bus.swlen !== 8'd3) begin miscompares++;
      $display("FAIL basic_swlen: got %0d expected 3", bus.swlen); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++;
      $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    tick();
    vectors++; if (bus.init !== 1'b1) begin miscompares++;
      $display("FAIL basic_init_high: got %b expected 1", bus.init); end
    tick();
    bus.swstat = 1'b1;
    repeat (6) tick();
    bus.swstat = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++;
      $display("FAIL basic_busy_close: got %b expected 1", bus.busy); end
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL basic_busy_fall: got %b expected 0", bus.busy); end
    vectors++; if (bus.txdata !== 8'hA3) begin miscompares++;
      $display("FAIL basic_txdata_hold: got %h expected a3", bus.txdata); end
    vectors++; if (init_lows - snap_init !== 1) begin miscompares++;
      $display("FAIL basic_init_cycles: got %0d expected 1", init_lows - snap_init); end
    vectors++; if (dones - snap_done !== 1) begin miscompares++;
      $display("FAIL basic_done_count: got %0d expected 1", dones - snap_done); end
    exp = '{8'hA1, 8'hA2, 8'hA3};
    vectors++; if (tx_q.size() - snap_tx !== exp.size()) begin miscompares++;
      $display("FAIL basic_tx_count: got %0d expected %0d", tx_q.size() - snap_tx, exp.size()); end
    foreach (exp[i]) begin
      got = (snap_tx + i < tx_q.size()) ? tx_q[snap_tx + i] : 8'hxx;
      vectors++; if (got !== exp[i]) begin miscompares++;
        $display("FAIL basic_word%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_short();
    logic [7:0] exp [$];
    logic [7:0] got;
    int snap_tx = tx_q.size();
    int snap_short = shorts;
    int snap_done = dones;
    for (int i = 1; i <= 5; i++) write_word(8'hB0 + 8'(i));
    pulse_start();
    vectors++; if (bus.swlen !== 8'd5) begin miscompares++;
      $display("FAIL short_swlen: got %0d expected 5", bus.swlen); end
    tick();
    bus.swstat = 1'b1;
    tick(); tick();
    bus.swstat = 1'b0;
    tick();
    vectors++; if (bus.short_err !== 1'b1 || bus.txvalid !== 1'b0) begin miscompares++;
      $display("FAIL short_pulse: got short=%b txvalid=%b expected short=1 txvalid=0",
               bus.short_err, bus.txvalid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL short_idle: got busy=%b expected 0", bus.busy); end
    tick();
    vectors++; if (tx_q.size() - snap_tx !== 2) begin miscompares++;
      $display("FAIL short_first_count: got %0d expected 2", tx_q.size() - snap_tx); end
    pulse_start();
    vectors++; if (bus.swlen !== 8'd3) begin miscompares++;
      $display("FAIL short_retry_swlen: got %0d expected 3", bus.swlen); end
    serve_window(4);
    vectors++; if (shorts - snap_short !== 1 || dones - snap_done !== 1) begin miscompares++;
      $display("FAIL short_pulses: got short=%0d done=%0d expected 1/1",
               shorts - snap_short, dones - snap_done); end
    exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    vectors++; if (tx_q.size() - snap_tx !== exp.size()) begin miscompares++;
      $display("FAIL short_tx_count: got %0d expected %0d", tx_q.size() - snap_tx, exp.size()); end
    foreach (exp[i]) begin
      got = (snap_tx + i < tx_q.size()) ? tx_q[snap_tx + i] : 8'hxx;
      vectors++; if (got !== exp[i]) begin miscompares++;
        $display("FAIL short_word%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [$];
    logic [7:0] got;
    int snap_tx = tx_q.size();
    int snap_tout = touts;
    write_word(8'hC1); write_word(8'hC2);
    pulse_start();
    repeat (16) tick();
    vectors++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin miscompares++;
      $display("FAIL tout_early: got tout=%b busy=%b expected 0/1", bus.timeout_err, bus.busy); end
    tick();
    vectors++; if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL tout_pulse: got tout=%b busy=%b expected 1/0", bus.timeout_err, bus.busy); end
    tick();
    vectors++; if (touts - snap_tout !== 1) begin miscompares++;
      $display("FAIL tout_count: got %0d expected 1", touts - snap_tout); end
    vectors++; if (tx_q.size() - snap_tx !== 0) begin miscompares++;
      $display("FAIL tout_no_tx: got %0d expected 0", tx_q.size() - snap_tx); end
    pulse_start();
    vectors++; if (bus.swlen !== 8'd2) begin miscompares++;
      $display("FAIL tout_retry_swlen: got %0d expected 2", bus.swlen); end
    serve_window(3);
    exp = '{8'hC1, 8'hC2};
    vectors++; if (tx_q.size() - snap_tx !== exp.size()) begin miscompares++;
      $display("FAIL tout_tx_count: got %0d expected %0d", tx_q.size() - snap_tx, exp.size()); end
    foreach (exp[i]) begin
      got = (snap_tx + i < tx_q.size()) ? tx_q[snap_tx + i] : 8'hxx;
      vectors++; if (got !== exp[i]) begin miscompares++;
        $display("FAIL tout_word%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_full();
    logic [7:0] exp [$];
    logic [7:0] got;
    int snap_tx = tx_q.size();
    for (int i = 0; i < 8; i++) write_word(8'hD0 + 8'(i));
    vectors++; if (bus.wready !== 1'b0) begin miscompares++;
      $display("FAIL full_wready: got %b expected 0", bus.wready); end
    write_word(8'hEE);
    vectors++; if (bus.wready !== 1'b0) begin miscompares++;
      $display("FAIL full_ninth: got wready=%b expected 0", bus.wready); end
    pulse_start();
    vectors++; if (bus.swlen !== 8'd8) begin miscompares++;
      $display("FAIL full_swlen: got %0d expected 8", bus.swlen); end
    tick();
    bus.swstat = 1'b1;
    tick();
    // Pushes now coincide with pops and belong to the next window.
    bus.wdata = 8'hE0; bus.wvalid = 1'b1;
    tick();
    vectors++; if (bus.wready !== 1'b1) begin miscompares++;
      $display("FAIL full_wready_serve: got %b expected 1", bus.wready); end
    bus.wdata = 8'hE1;
    tick();
    bus.wvalid = 1'b0;
    repeat (7) tick();
    bus.swstat = 1'b0;
    repeat (3) tick();
    exp = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
    vectors++; if (tx_q.size() - snap_tx !== exp.size()) begin miscompares++;
      $display("FAIL full_tx_count: got %0d expected %0d", tx_q.size() - snap_tx, exp.size()); end
    pulse_start();
    vectors++; if (bus.swlen !== 8'd2) begin miscompares++;
      $display("FAIL full_next_swlen: got %0d expected 2", bus.swlen); end
    serve_window(3);
    exp.push_back(8'hE0); exp.push_back(8'hE1);
    foreach (exp[i]) begin
      got = (snap_tx + i < tx_q.size()) ? tx_q[snap_tx + i] : 8'hxx;
      vectors++; if (got !== exp[i]) begin miscompares++;
        $display("FAIL full_word%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] exp [$];
    logic [7:0] got;
    int snap_tx;
    int snap_init = init_lows;
    pulse_start();
    vectors++; if (bus.init !== 1'b1 || bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL empty_start: got init=%b busy=%b expected 1/0", bus.init, bus.busy); end
    tick();
    vectors++; if (init_lows - snap_init !== 0) begin miscompares++;
      $display("FAIL empty_init_cycles: got %0d expected 0", init_lows - snap_init); end
    snap_tx = tx_q.size();
    write_word(8'hF1); write_word(8'hF2); write_word(8'hF3);
    pulse_start();
    tick();
    bus.swstat = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++; if (bus.swlen !== 8'd3 || bus.busy !== 1'b1) begin miscompares++;
      $display("FAIL serve_start_swlen: got swlen=%0d busy=%b expected 3/1", bus.swlen, bus.busy); end
    repeat (3) tick();
    bus.swstat = 1'b0;
    repeat (3) tick();
    vectors++; if (init_lows - snap_init !== 1 || bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL serve_start_init: got inits=%0d busy=%b expected 1/0",
               init_lows - snap_init, bus.busy); end
    exp = '{8'hF1, 8'hF2, 8'hF3};
    vectors++; if (tx_q.size() - snap_tx !== exp.size()) begin miscompares++;
      $display("FAIL serve_start_count: got %0d expected %0d", tx_q.size() - snap_tx, exp.size()); end
    foreach (exp[i]) begin
      got = (snap_tx + i < tx_q.size()) ? tx_q[snap_tx + i] : 8'hxx;
      vectors++; if (got !== exp[i]) begin miscompares++;
        $display("FAIL serve_start_word%0d: got %h expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_serve();
    int snap_tx = tx_q.size();
    int snap_init;
    for (int i = 1; i <= 4; i++) write_word(8'h90 + 8'(i));
    pulse_start();
    tick();
    bus.swstat = 1'b1;
    tick();
    vectors++; if (bus.txvalid !== 1'b1 || bus.txdata !== 8'h91) begin miscompares++;
      $display("FAIL rst_first_word: got valid=%b data=%h expected 1/91", bus.txvalid, bus.txdata); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.swstat = 1'b0;
    vectors++; if (bus.init !== 1'b1 || bus.swlen !== 8'h00 || bus.txdata !== 8'h00) begin
      miscompares++; $display("FAIL rst_mid_regs: got init=%b swlen=%h txdata=%h expected 1/00/00",
        bus.init, bus.swlen, bus.txdata); end
    vectors++; if ({bus.txvalid, bus.busy, bus.done, bus.timeout_err, bus.short_err} !== 5'b0)
      begin miscompares++; $display("FAIL rst_mid_flags: got %b expected 00000",
        {bus.txvalid, bus.busy, bus.done, bus.timeout_err, bus.short_err}); end
    vectors++; if (bus.wready !== 1'b1) begin miscompares++;
      $display("FAIL rst_mid_wready: got %b expected 1", bus.wready); end
    snap_init = init_lows;
    pulse_start();
    vectors++; if (bus.init !== 1'b1 || bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL rst_empty_start: got init=%b busy=%b expected 1/0", bus.init, bus.busy); end
    repeat (3) tick();
    vectors++; if (init_lows - snap_init !== 0 || tx_q.size() - snap_tx !== 1) begin
      miscompares++; $display("FAIL rst_after: got inits=%0d words=%0d expected 0/1",
        init_lows - snap_init, tx_q.size() - snap_tx); end
  endtask

  initial begin
    bus.wdata  = 8'h00;
    bus.wvalid = 1'b0;
    bus.start  = 1'b0;
    bus.swstat = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_timeout();
    test_full();
    test_ignored_start();
    test_reset_mid_serve();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/service_window_client.md
# service_window_client

Initiator-side controller for the service-window handshake. It buffers outgoing 8-bit words and, on request, requests a window by driving a one-cycle active-low INIT pulse with SWLEN set to the number of queued words. While the window's SWSTAT is high, it drains the queued words one per cycle onto TXDATA/TXVALID. It sits between a host producer and the service_window block and reports completion, timeout and early-close conditions.

## Interface
- DEPTH, 8: FIFO depth in words; power of two, 2..128.
- TIMEOUT, 16: max cycles to wait in WAIT_OPEN for SWSTAT high; must be ≥ 2.

- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- WDATA  in  8  word to enqueue.
- WVALID  in  1  enqueue request.
- WREADY  out  1  FIFO not full (count < DEPTH).
- START  in  1  one-cycle request to open a window.
- INIT  out  1  window request to service_window, active-low, exactly one cycle low per request.
- SWLEN  out  8  window length in words, held stable from the INIT-low cycle until return to IDLE.
- SWSTAT  in  1  window open status from service_window.
- TXDATA  out  8  served word.
- TXVALID  out  1  TXDATA valid this cycle.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse: all SWLEN words sent.
- TIMEOUT_ERR  out  1  one-cycle pulse: window never opened.
- SHORT_ERR  out  1  one-cycle pulse: window closed with words remaining.

## Operation
- FIFO: a write occurs when WVALID && WREADY. A pop occurs only as described under WAIT_OPEN and SERVE below. A write and pop in the same cycle leave count unchanged. Writes are accepted in every state.
- States: IDLE, ARM, WAIT_OPEN, SERVE, CLOSE.
- IDLE: START && count>0 goes to ARM. On that transition, SWLEN and the remaining counter are loaded with count. START with count==0 is ignored, with no outputs. START in non-IDLE states is ignored.
- ARM: INIT=0 for this one cycle, then WAIT_OPEN with the timer cleared.
- WAIT_OPEN:
  - SWSTAT sampled 1: pop the head word into TXDATA, set TXVALID=1 next cycle, decrement remaining, go to SERVE.
  - Otherwise the timer increments. When the timer reaches TIMEOUT−1, pulse TIMEOUT_ERR and go to IDLE. FIFO contents are retained.
- SERVE:
  - SWSTAT=1 && remaining>0: pop, TXVALID, decrement.
  - remaining==0: pulse DONE, go to CLOSE.
  - SWSTAT=0 && remaining>0: pulse SHORT_ERR, go to IDLE. Unsent words stay queued in order.
- CLOSE: wait for SWSTAT=0, then go to IDLE. If SWSTAT is already 0, go to IDLE on the next cycle.
- Words written after START are not counted in the current SWLEN. They are served in a later window.
- Reset, including mid-operation: state IDLE, FIFO emptied, pointers and counters cleared.

## Timing
- Reset values: INIT=1, SWLEN=0, TXDATA=0, TXVALID=0, BUSY=0, DONE=0, TIMEOUT_ERR=0, SHORT_ERR=0, WREADY=1.
- All outputs are registered except WREADY, which is combinational from count.
- START sampled at edge k: INIT is low for the cycle between edges k+1 and k+2. SWLEN is valid from edge k+1. BUSY is high from edge k+1.
- SWSTAT sampled high at edge e: the first TXVALID is high from edge e+1. Words are then back-to-back, one per cycle, while SWSTAT stays high.
- DONE is high for the one cycle immediately after the last TXVALID cycle.
- TIMEOUT_ERR fires after exactly TIMEOUT cycles in WAIT_OPEN without SWSTAT.
- SHORT_ERR is high for the cycle after the first SWSTAT=0 sample in SERVE. TXVALID is 0 in that cycle.
- TXDATA holds its last value when TXVALID=0.

## Test plan
- Reset, then write 3 words 0xA1, 0xA2, 0xA3, then pulse START. Required response:
  - INIT low for exactly 1 cycle, SWLEN=3.
  - Model SWSTAT high for 6 cycles, starting 2 cycles after INIT.
  - TXDATA A1, A2, A3 on 3 consecutive TXVALID cycles.
  - DONE pulses once, and BUSY falls after SWSTAT falls.
- Write 5 words, START, SWSTAT high for only 2 cycles. Required response:
  - 2 words sent, then SHORT_ERR pulse, return to IDLE.
  - A second START gives SWLEN=3, and the remaining 3 words are sent in order.
- START with SWSTAT held low and TIMEOUT=16. Required response:
  - TIMEOUT_ERR after 16 WAIT_OPEN cycles, no TXVALID.
  - FIFO count unchanged, and a retry serves all words.
- Fill to DEPTH=8. Required response:
  - WREADY=0, and a 9th write is dropped.
  - During serving, simultaneous write and pop keep count unchanged.
  - Words written after START are absent from the current window.
- START with empty FIFO gives no INIT. START during SERVE is ignored.
- RST asserted mid-SERVE after 1 of 4 words. Required response:
  - Next cycle all outputs are at reset values and WREADY=1.
  - A following START with an empty FIFO gives no INIT.
